// File: rtl/alu_issue_if.sv
// Execute-stage bundle: decode-side handshake and fields, alu operand/result wires,
// and the result handshake toward writeback.
interface alu_issue_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
);
   logic                     InValid;
   logic                     InReady;
   logic [1:0]               ALUOp;
   logic [2:0]               Funct3;
   logic [6:0]               Funct7;
   logic [DATA_WIDTH-1:0]    OpA;
   logic [DATA_WIDTH-1:0]    OpB;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic [DATA_WIDTH-1:0]    ALUResult;
   logic                     OutValid;
   logic                     OutReady;
   logic [DATA_WIDTH-1:0]    Result;
   logic                     IllegalOp;

   // The issue stage is the master: it drives the alu and the result handshake.
   modport master (
      input  InValid, ALUOp, Funct3, Funct7, OpA, OpB, ALUResult, OutReady,
      output InReady, SrcA, SrcB, Operation, OutValid, Result, IllegalOp
   );

   modport slave (
      output InValid, ALUOp, Funct3, Funct7, OpA, OpB, ALUResult, OutReady,
      input  InReady, SrcA, SrcB, Operation, OutValid, Result, IllegalOp
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage (E issue, R result) ALU issue pipeline with valid/ready handshakes.
// Define ALU_ISSUE_PERF_EN to add the IssueCount/IllegalCount performance counters.
module alu_issue_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_if.master bus
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0] IssueCount,
   output logic [31:0] IllegalCount
`endif
);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic                     eValid;
   logic                     eIllegal;
   logic [DATA_WIDTH-1:0]    srcAReg;
   logic [DATA_WIDTH-1:0]    srcBReg;
   logic [OPCODE_LENGTH-1:0] opReg;

   logic                     outValidReg;
   logic [DATA_WIDTH-1:0]    resultReg;
   logic                     illegalReg;

   logic [OPCODE_LENGTH-1:0] decOp;
   logic                     decIllegal;
   logic                     advR;
   logic                     accept;

   // Anything that does not match a supported encoding falls through to the illegal code.
   always_comb begin
      decOp      = OP_ILL;
      decIllegal = 1'b1;
      case (bus.ALUOp)
         2'b00: begin
            decOp      = OP_ADD;
            decIllegal = 1'b0;
         end
         2'b01: begin
            if (bus.Funct3 == 3'b000) begin
               decOp      = OP_EQ;
               decIllegal = 1'b0;
            end
         end
         2'b10: begin
            if (bus.Funct7 == F7_BASE) begin
               case (bus.Funct3)
                  3'b000:  begin decOp = OP_ADD; decIllegal = 1'b0; end
                  3'b100:  begin decOp = OP_XOR; decIllegal = 1'b0; end
                  3'b110:  begin decOp = OP_OR;  decIllegal = 1'b0; end
                  3'b111:  begin decOp = OP_AND; decIllegal = 1'b0; end
                  default: begin decOp = OP_ILL; decIllegal = 1'b1; end
               endcase
            end else if (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b000) begin
               decOp      = OP_SUB;
               decIllegal = 1'b0;
            end
         end
         default: begin
            case (bus.Funct3)
               3'b000:  begin decOp = OP_ADD; decIllegal = 1'b0; end
               3'b100:  begin decOp = OP_XOR; decIllegal = 1'b0; end
               3'b110:  begin decOp = OP_OR;  decIllegal = 1'b0; end
               3'b111:  begin decOp = OP_AND; decIllegal = 1'b0; end
               default: begin decOp = OP_ILL; decIllegal = 1'b1; end
            endcase
         end
      endcase
   end

   // InReady is derived only from stage occupancy and OutReady, never from InValid.
   assign advR        = !outValidReg || bus.OutReady;
   assign bus.InReady = !eValid || advR;
   assign accept      = bus.InValid && bus.InReady;

   // E stage: operand/opcode registers hold their value unless a new transaction loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eValid   <= 1'b0;
         eIllegal <= 1'b0;
         srcAReg  <= '0;
         srcBReg  <= '0;
         opReg    <= OP_AND;
      end else if (accept) begin
         eValid   <= 1'b1;
         eIllegal <= decIllegal;
         srcAReg  <= bus.OpA;
         srcBReg  <= bus.OpB;
         opReg    <= decOp;
      end else if (advR) begin
         eValid   <= 1'b0;
      end
   end

   // R stage: captures the combinational alu output whenever it can advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValidReg <= 1'b0;
         resultReg   <= '0;
         illegalReg  <= 1'b0;
      end else if (advR) begin
         outValidReg <= eValid;
         if (eValid) begin
            resultReg  <= bus.ALUResult;
            illegalReg <= eIllegal;
         end
      end
   end

   assign bus.SrcA      = srcAReg;
   assign bus.SrcB      = srcBReg;
   assign bus.Operation = opReg;
   assign bus.OutValid  = outValidReg;
   assign bus.Result    = resultReg;
   assign bus.IllegalOp = illegalReg;

`ifdef ALU_ISSUE_PERF_EN
   // Counters wrap naturally at 32 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         IssueCount   <= 32'd0;
         IllegalCount <= 32'd0;
      end else if (accept) begin
         IssueCount <= IssueCount + 32'd1;
         if (decIllegal) begin
            IllegalCount <= IllegalCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage with a transaction-level reference model.
module tb_alu_issue_stage;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

   // Stand-in for the downstream combinational alu.
   logic [31:0] aluRes;
   always_comb begin
      aluRes = 32'd0;
      case (bus.Operation)
         4'b0000: aluRes = bus.SrcA & bus.SrcB;
         4'b0001: aluRes = bus.SrcA | bus.SrcB;
         4'b0010: aluRes = bus.SrcA + bus.SrcB;
         4'b0011: aluRes = bus.SrcA - bus.SrcB;
         4'b0100: aluRes = bus.SrcA ^ bus.SrcB;
         4'b1000: aluRes = (bus.SrcA == bus.SrcB) ? 32'd1 : 32'd0;
         default: aluRes = 32'd0;
      endcase
   end
   assign bus.ALUResult = aluRes;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] issueCount;
   logic [31:0] illegalCount;
   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .IssueCount(issueCount), .IllegalCount(illegalCount)
   );
`else
   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
`endif

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          cyc;
   } entry_t;

   entry_t      q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] issueModel = 32'd0;
   logic [31:0] illegalModel = 32'd0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Instruction-level meaning of each encoding; illegal encodings produce 0.
   function automatic void refModel(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ill);
      ill = 1'b0;
      res = 32'd0;
      case (aop)
         2'd0: res = a + b;
         2'd1: if (f3 == 3'd0) res = (a == b) ? 32'd1 : 32'd0; else ill = 1'b1;
         2'd2: begin
            if      (f7 == 7'h00 && f3 == 3'd0) res = a + b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
            else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
            else ill = 1'b1;
         end
         default: begin
            if      (f3 == 3'd0) res = a + b;
            else if (f3 == 3'd4) res = a ^ b;
            else if (f3 == 3'd6) res = a | b;
            else if (f3 == 3'd7) res = a & b;
            else ill = 1'b1;
         end
      endcase
      if (ill) res = 32'd0;
   endfunction

   // One clock: drive at negedge, check against the model, then advance the model at posedge.
   task automatic applyStimulus(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                input logic ordy, output logic accepted);
      logic   expReady;
      logic   expOutValid;
      logic   drain;
      entry_t e;
      @(negedge clk);
      bus.InValid  = v;
      bus.ALUOp    = aop;
      bus.Funct3   = f3;
      bus.Funct7   = f7;
      bus.OpA      = a;
      bus.OpB      = b;
      bus.OutReady = ordy;
      #1;
      expReady    = !(q.size() >= 2 && !ordy);
      expOutValid = (q.size() > 0) && (q[0].cyc < cyc);
      checkOutput("InReady", 32'(bus.InReady), 32'(expReady));
      checkOutput("OutValid", 32'(bus.OutValid), 32'(expOutValid));
      if (expOutValid) begin
         checkOutput("Result", bus.Result, q[0].res);
         checkOutput("IllegalOp", 32'(bus.IllegalOp), 32'(q[0].ill));
      end
      accepted = v && expReady;
      drain    = expOutValid && ordy;
      @(posedge clk);
      cyc++;
      if (drain) void'(q.pop_front());
      if (accepted) begin
         refModel(aop, f3, f7, a, b, e.res, e.ill);
         e.cyc = cyc;
         q.push_back(e);
         issueModel = issueModel + 32'd1;
         if (e.ill) illegalModel = illegalModel + 32'd1;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_InReady"}, 32'(bus.InReady), 32'd1);
      checkOutput({tag, "_OutValid"}, 32'(bus.OutValid), 32'd0);
      checkOutput({tag, "_Result"}, bus.Result, 32'd0);
      checkOutput({tag, "_IllegalOp"}, 32'(bus.IllegalOp), 32'd0);
      checkOutput({tag, "_SrcA"}, bus.SrcA, 32'd0);
      checkOutput({tag, "_SrcB"}, bus.SrcB, 32'd0);
      checkOutput({tag, "_Operation"}, 32'(bus.Operation), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
      checkOutput({tag, "_IssueCount"}, issueCount, 32'd0);
      checkOutput({tag, "_IllegalCount"}, illegalCount, 32'd0);
`endif
   endtask

   initial begin
      logic        acc;
      logic        pv;
      logic [1:0]  paop;
      logic [2:0]  pf3;
      logic [6:0]  pf7;
      logic [31:0] pa;
      logic [31:0] pb;
      int          k;

      bus.InValid  = 1'b0;
      bus.ALUOp    = 2'b00;
      bus.Funct3   = 3'b000;
      bus.Funct7   = 7'b0;
      bus.OpA      = 32'd0;
      bus.OpB      = 32'd0;
      bus.OutReady = 1'b1;

      #3;
      checkResetState("por");
      @(negedge clk);
      rst_n = 1'b1;

      // R-type SUB 10-3
      applyStimulus(1'b1, 2'b10, 3'b000, 7'b0100000, 32'd10, 32'd3, 1'b1, acc);
      #1;
      checkOutput("sub_Operation", 32'(bus.Operation), 32'h3);
      checkOutput("sub_SrcA", bus.SrcA, 32'd10);
      checkOutput("sub_SrcB", bus.SrcB, 32'd3);

      // Branch equal then not-equal
      applyStimulus(1'b1, 2'b01, 3'b000, 7'b0, 32'h55, 32'h55, 1'b1, acc);
      #1;
      checkOutput("beq_Operation", 32'(bus.Operation), 32'h8);
      applyStimulus(1'b1, 2'b01, 3'b000, 7'b0, 32'h55, 32'h56, 1'b1, acc);

      // Illegal R-type funct3
      applyStimulus(1'b1, 2'b10, 3'b001, 7'b0, 32'h1234, 32'h5678, 1'b1, acc);
      #1;
      checkOutput("ill_Operation", 32'(bus.Operation), 32'hF);

      applyStimulus(1'b1, 2'b00, 3'b000, 7'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, acc);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 32'd0, 32'd0, 1'b1, acc);
`ifdef ALU_ISSUE_PERF_EN
      checkOutput("perf_issue5", issueCount, 32'd5);
      checkOutput("perf_illegal1", illegalCount, 32'd1);
`endif

      // Backpressure: 4 ADDs with OutReady low for the first 3 cycles
      k = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(k < 4, 2'b00, 3'b000, 7'b0, 32'(100 + k), 32'(k), c >= 3, acc);
         if (acc) k++;
      end

      // Randomized traffic with random backpressure
      pv = 1'b0; paop = 2'b00; pf3 = 3'b000; pf7 = 7'b0; pa = 32'd0; pb = 32'd0;
      for (int i = 0; i < 400; i++) begin
         if (!pv && $urandom_range(0, 9) < 7) begin
            pv   = 1'b1;
            paop = 2'($urandom);
            case ($urandom_range(0, 5))
               0:       pf3 = 3'b000;
               1:       pf3 = 3'b100;
               2:       pf3 = 3'b110;
               3:       pf3 = 3'b111;
               default: pf3 = 3'($urandom);
            endcase
            case ($urandom_range(0, 3))
               2:       pf7 = 7'b0100000;
               3:       pf7 = 7'($urandom);
               default: pf7 = 7'b0;
            endcase
            pa = $urandom;
            pb = ($urandom_range(0, 3) == 0) ? pa : $urandom;
         end
         applyStimulus(pv, paop, pf3, pf7, pa, pb, $urandom_range(0, 9) < 7, acc);
         if (acc) pv = 1'b0;
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 32'd0, 32'd0, 1'b1, acc);
`ifdef ALU_ISSUE_PERF_EN
      checkOutput("perf_issue", issueCount, issueModel);
      checkOutput("perf_illegal", illegalCount, illegalModel);
`endif

      // Reset mid-stream with both stages full
      applyStimulus(1'b1, 2'b00, 3'b000, 7'b0, 32'd5, 32'd6, 1'b0, acc);
      applyStimulus(1'b1, 2'b00, 3'b000, 7'b0, 32'd7, 32'd8, 1'b0, acc);
      @(negedge clk);
      #2;
      checkOutput("full_OutValid", 32'(bus.OutValid), 32'd1);
      checkOutput("full_InReady", 32'(bus.InReady), 32'd0);
      rst_n = 1'b0;
      #1;
      checkResetState("midrst");
      q.delete();
      issueModel   = 32'd0;
      illegalModel = 32'd0;
      @(negedge clk);
      bus.InValid = 1'b0;
      rst_n       = 1'b1;
      applyStimulus(1'b1, 2'b11, 3'b100, 7'h7F, 32'hF0F0, 32'h0FF0, 1'b1, acc);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 32'd0, 32'd0, 1'b1, acc);

`ifdef ALU_ISSUE_PERF_EN
      // Counter wrap from all-ones
      @(negedge clk);
      force dut.IssueCount = 32'hFFFF_FFFF;
      #1;
      release dut.IssueCount;
      issueModel = 32'hFFFF_FFFF;
      applyStimulus(1'b1, 2'b00, 3'b000, 7'b0, 32'd1, 32'd1, 1'b1, acc);
      #1;
      checkOutput("perf_wrap", issueCount, issueModel);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
